dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//   Multi-cycle data-memory responder on the MEM-stage side of the pipelined CPU. It serves the
//   CPU's load/store requests (MemRead/MemWrite, addr, store data) after a programmable latency
//   from an internal word array. It stalls the pipeline via stall_o until ack_o and flags
//   illegal accesses. It replaces the single-cycle data memory behind the EX_MEM register.
// PARAMETERS
//   DATA_W   32   data and address width in bits
//   DEPTH    256  number of DATA_W-bit words in the array (power of 2)
//   LATENCY  4    BUSY cycles per legal access; legal range 1..15
// PORTS
//   clk_i       in   1       single clock, rising edge
//   rst_i       in   1       asynchronous, active-high reset
//   MemRead_i   in   1       load request, from the EX_MEM MemRead output
//   MemWrite_i  in   1       store request, from the EX_MEM MemWrite output
//   addr_i      in   DATA_W  byte address (ALU result)
//   data_i      in   DATA_W  store data (forwarded rt data)
//   data_o      out  DATA_W  load data, to the MEM_WB mem input; registered
//   stall_o     out  1       freeze PC, IF_ID, ID_EX and EX_MEM while high
//   ack_o       out  1       one-cycle pulse: access complete
//   err_o       out  1       qualifies ack_o: access rejected
// BEHAVIOUR
//   Reset and defaults
//   - Reset forces state IDLE, data_o=0, ack_o=0, err_o=0 and cnt=0.
//   - stall_o is held 0 while rst_i is high.
//   - Array contents are NOT reset.
//   - A reset mid-access abandons it; a pending store is never committed.
//   Request and legality
//   - req = MemRead_i | MemWrite_i.
//   - An access is illegal if any of these holds: both MemRead_i and MemWrite_i are high;
//     addr_i[1:0] != 0; or word index addr_i[DATA_W-1:2] >= DEPTH.
//   State machine {IDLE, BUSY, DONE}, 2-bit encoding
//   - IDLE, legal req: latch op/addr/data, cnt<=LATENCY-1, go BUSY.
//   - IDLE, illegal req: latch err, go DONE; no BUSY cycles and no array access.
//   - IDLE, no req: stay.
//   - BUSY, cnt!=0: decrement cnt.
//   - BUSY, cnt==0 on a store: write array[word] <= latched data at this edge.
//   - BUSY, cnt==0 on a load: data_o <= array[word].
//   - BUSY, cnt==0: go DONE.
//   - DONE: ack_o=1 and err_o=latched err for exactly this cycle, then go IDLE unconditionally.
//     Request inputs are ignored in DONE; they still show the old instruction.
//   stall_o (combinational)
//   - stall_o = (IDLE & req) | BUSY; it is 0 in DONE, so the pipeline advances at the end of DONE.
//   Latency
//   - Request first seen in cycle 0; ack_o is seen in cycle LATENCY+1.
//   - stall_o is high for LATENCY+1 cycles for a legal access, 1 cycle for an illegal one.
//   - Back-to-back requests: the next request can be accepted in the IDLE cycle right after DONE.
//     Peak throughput is one access per LATENCY+2 cycles.
//   data_o rules
//   - Holds its value until the next load completes; a store does not change it.
//   - Set to 0 on an err completion.
//   Outputs ack_o and err_o are registered, decoded from state DONE.
// STRUCTURE
//   - Package dmem_pkg: state typedef (IDLE=2'd0, BUSY=2'd1, DONE=2'd2), DATA_W, DEPTH and
//     the word-index slice width localparam $clog2(DEPTH).
//   - One sub-module dmem_array: synchronous-write, synchronous-read single-port RAM.
//     Ports: clk_i, we_i, re_i, idx_i, wdata_i, rdata_o. The FSM and counter stay in
//     dmem_responder.
// TESTING
//   1. Legal access, LATENCY=4: store 32'hDEADBEEF @0x10, then load @0x10.
//      -> stall_o high 5 cycles per access; ack_o in cycle 5; data_o=32'hDEADBEEF; err_o=0.
//   2. Misaligned load @0x13 -> stall_o high 1 cycle; ack_o and err_o high in cycle 1;
//      data_o=0; array unchanged.
//   3. Illegal requests:
//      - MemRead_i and MemWrite_i both high @0x20 -> err_o=1; no write.
//      - Load @ DEPTH*4 (0x400) -> err_o=1.
//   4. Back-to-back: load @0x0 held through DONE, then load @0x4 in the next cycle.
//      -> exactly two ack_o pulses 6 cycles apart; no duplicate access from the DONE cycle.
//   5. Reset mid-access: assert rst_i in the 2nd BUSY cycle of a store of 32'h1234 @0x8.
//      -> state IDLE and all outputs 0 immediately; a later load @0x8 returns the old value.
//   6. LATENCY=1 build: store then load @0x3FC.
//      -> ack_o 2 cycles after each request; data_o correct at the top word.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the multi-cycle data-memory responder.
//   state_t : FSM state encoding (IDLE, BUSY, DONE)
//   DATA_W  : default data/address width
//   DEPTH   : default number of words in the array
//   IDX_W   : width of the word-index slice for the default DEPTH
//   CNT_W   : width of the latency down-counter (covers LATENCY 1..15)
package dmem_pkg;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 256;
   localparam int IDX_W  = $clog2(DEPTH);
   localparam int CNT_W  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with synchronous write and synchronous read.
//   clk_i   : clock, rising edge
//   we_i    : write enable, stores wdata_i at idx_i
//   re_i    : read enable, registers mem[idx_i] into rdata_o
//   idx_i   : word index
//   wdata_i : write data
//   rdata_o : registered read data, held until the next read
module dmem_array #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256,
   parameter int IDX_W  = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic              re_i,
   input  logic [IDX_W-1:0]  idx_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) mem[idx_i] <= wdata_i;
      if (re_i) rdata_o <= mem[idx_i];
   end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage. Serves loads and stores
// after LATENCY busy cycles, stalls the pipeline until completion and flags
// illegal accesses (read+write together, misaligned, or out of range).
//   clk_i      : clock, rising edge
//   rst_i      : asynchronous active-high reset
//   MemRead_i  : load request
//   MemWrite_i : store request
//   addr_i     : byte address
//   data_i     : store data
//   data_o     : load data, held until the next load completes, 0 after an error
//   stall_o    : freezes the upstream pipeline while high
//   ack_o      : one-cycle completion pulse
//   err_o      : qualifies ack_o, access was rejected
module dmem_responder #(
   parameter int DATA_W  = dmem_pkg::DATA_W,
   parameter int DEPTH   = dmem_pkg::DEPTH,
   parameter int LATENCY = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              MemRead_i,
   input  logic              MemWrite_i,
   input  logic [DATA_W-1:0] addr_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [DATA_W-1:0] data_o,
   output logic              stall_o,
   output logic              ack_o,
   output logic              err_o
);

   import dmem_pkg::*;

   localparam int AW = $clog2(DEPTH);

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic              op_wr;
   logic              err_q;
   logic              zero_q;
   logic [AW-1:0]     idx_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata;
   logic              req;
   logic              illegal;
   logic              last;

   assign req = MemRead_i | MemWrite_i;

   // Any address bit above the word index means the word lies beyond DEPTH.
   assign illegal = (MemRead_i & MemWrite_i)
                  | (addr_i[1:0] != 2'b00)
                  | ((addr_i >> (AW + 2)) != '0);

   assign last = (state == BUSY) && (cnt == '0);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req) state_nxt = illegal ? DONE : BUSY;
         BUSY:    if (cnt == '0) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state  <= IDLE;
         cnt    <= '0;
         op_wr  <= 1'b0;
         err_q  <= 1'b0;
         zero_q <= 1'b1;
      end else begin
         state <= state_nxt;
         if (state == IDLE && req) begin
            if (illegal) begin
               err_q  <= 1'b1;
               zero_q <= 1'b1;
            end else begin
               err_q <= 1'b0;
               op_wr <= MemWrite_i;
               cnt   <= CNT_W'(LATENCY - 1);
            end
         end
         if (state == BUSY && cnt != '0) cnt <= cnt - 1'b1;
         // A completed load exposes the RAM read register again.
         if (last && !op_wr) zero_q <= 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (state == IDLE && req && !illegal) begin
         idx_q   <= addr_i[AW+1:2];
         wdata_q <= data_i;
      end
   end

   // Gating with rst_i keeps a store whose last BUSY edge coincides with
   // reset from being committed.
   dmem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (AW)
   ) u_array (
      .clk_i   (clk_i),
      .we_i    (last & op_wr & ~rst_i),
      .re_i    (last & ~op_wr & ~rst_i),
      .idx_i   (idx_q),
      .wdata_i (wdata_q),
      .rdata_o (rdata)
   );

   // The RAM read register is the load-data holding register; zero_q masks
   // it after reset and after an error completion.
   assign data_o  = zero_q ? '0 : rdata;
   assign ack_o   = (state == DONE);
   assign err_o   = (state == DONE) & err_q;
   assign stall_o = ~rst_i & (((state == IDLE) & req) | (state == BUSY));

endmodule
